// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction classes and the fetch-queue entry.
// No timing or flow control of its own; consumed by the fetch front-end.
package mips32_pkg;

    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] AND   = 6'b000010;
    localparam logic [5:0] OR    = 6'b000011;
    localparam logic [5:0] SLT   = 6'b000100;
    localparam logic [5:0] MUL   = 6'b000101;
    localparam logic [5:0] HLT   = 6'b111111;
    localparam logic [5:0] LW    = 6'b001000;
    localparam logic [5:0] SW    = 6'b001001;
    localparam logic [5:0] ADDI  = 6'b001010;
    localparam logic [5:0] SUBI  = 6'b001011;
    localparam logic [5:0] SLTI  = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101;
    localparam logic [5:0] BEQZ  = 6'b001110;

    typedef enum logic [2:0] {
        RR_ALU = 3'b000,
        RM_ALU = 3'b001,
        LOAD   = 3'b010,
        STORE  = 3'b011,
        BRANCH = 3'b100,
        HALT   = 3'b101
    } instr_type_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } fetch_entry_t;

    // Unknown opcodes classify as register ALU ops so they flow through untouched.
    function automatic instr_type_e instr_type(input logic [5:0] op);
        instr_type_e t;
        t = RR_ALU;
        case (op)
            ADD, SUB, AND, OR, SLT, MUL: t = RR_ALU;
            ADDI, SUBI, SLTI:            t = RM_ALU;
            LW:                          t = LOAD;
            SW:                          t = STORE;
            BNEQZ, BEQZ:                 t = BRANCH;
            HLT:                         t = HALT;
            default:                     t = RR_ALU;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips32_iq_fifo.sv
// Circular buffer of fetch entries with flush; head is read straight from storage registers.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller never pushes when full nor pops when empty.
module mips32_iq_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_dat,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    always_ff @(posedge clk1) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction fetch front-end: PC, imem request credit, HLT stop and redirect flush.
// Latency: request at t gives a decode-visible word at t+2; a redirect yields the target word at t+3.
// Backpressure: requests stall while queued + in-flight words reach DEPTH; the head holds while id_ready is low.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk1,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_ir,
    output logic [31:0]       id_npc,
    output logic              fetch_stopped
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          kill;
    logic [CW-1:0] count;
    logic [CW:0]   credit;
    logic          push;
    logic          pop;
    fetch_entry_t  push_dat;
    fetch_entry_t  head;

    // Credit counts words already requested, so a same-cycle pop never frees a slot.
    assign credit    = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req  = !reset && !fetch_stopped && !br_taken && (credit < DEPTH_C);
    assign imem_addr = fetch_pc[ADDR_W-1:0];

    assign push     = inflight && !kill && !fetch_stopped;
    assign id_valid = (count != '0);
    assign pop      = id_valid && id_ready && !br_taken;
    assign push_dat = '{ir: imem_rdata, npc: req_pc + 32'd1};

    always_ff @(posedge clk1) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            req_pc        <= '0;
            inflight      <= 1'b0;
            kill          <= 1'b0;
            fetch_stopped <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                req_pc <= fetch_pc;
            end
            if (br_taken) begin
                fetch_pc      <= br_target;
                fetch_stopped <= 1'b0;
                kill          <= inflight;
            end else begin
                kill <= 1'b0;
                if (imem_req) begin
                    fetch_pc <= fetch_pc + 32'd1;
                end
                if (push && instr_type(imem_rdata[31:26]) == HALT) begin
                    fetch_stopped <= 1'b1;
                end
            end
        end
    end

    mips32_iq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1     (clk1),
        .reset    (reset),
        .flush    (br_taken),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .count    (count),
        .head     (head)
    );

    assign id_ir  = head.ir;
    assign id_npc = head.npc;

endmodule
